// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetcher_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] word_t;

  localparam word_t ZERO = 32'h0000_0000;

  // Default cache index width: 2^5 = 32 one-word lines.
  localparam int DEF_ICACHE_IDX_W = 5;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache: one 32-bit word per line, combinational
// lookup, single synchronous write port. Only the valid bits are reset.
module fetcher_icache
  import fetcher_pkg::*;
#(
  parameter int IDX_W = DEF_ICACHE_IDX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  input  logic [31-IDX_W-2+1:0] rd_tag_i,
  output logic                  hit_o,
  output word_t                 data_o,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [31-IDX_W-2+1:0] wr_tag_i,
  input  word_t                 wr_data_i
);

  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  word_t            data_q [DEPTH];

  assign hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign data_o = data_q[rd_idx_i];

  // Valid bits: cleared on reset, set when a line is filled; never invalidated otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: written on fill, contents meaningless until valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch front end: fetch PC, direct-mapped icache lookup and a
// byte-serial miss fill from the memory controller, with redirect abort.
module fetcher
  import fetcher_pkg::*;
#(
  parameter addr_t RESET_PC     = 32'h0,
  parameter int    ICACHE_IDX_W = DEF_ICACHE_IDX_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       issue,
  input  logic       jump_en,
  input  addr_t      jump_addr,
  input  logic       mem_valid,
  input  logic [7:0] mem_byte,
  output logic       mem_req,
  output addr_t      mem_addr,
  output logic       hit,
  output addr_t      pc_out,
  output inst_t      inst_out
);

  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  fetch_state_e            state_q;
  addr_t                   pc_q;
  logic                    mem_req_q;
  addr_t                   mem_addr_q;
  logic [1:0]              byte_cnt_q;
  word_t                   fill_buf_q;

  logic [ICACHE_IDX_W-1:0] idx_d;
  logic [TAG_W-1:0]        tag_d;
  logic                    lookup_hit_d;
  word_t                   line_data_d;
  logic                    hit_d;
  logic                    fill_we_d;
  addr_t                   pc_inc_d;
  addr_t                   jump_pc_d;

  assign idx_d     = pc_q[ICACHE_IDX_W+1:2];
  assign tag_d     = pc_q[31:ICACHE_IDX_W+2];
  assign pc_inc_d  = pc_q + 32'd4;
  // Redirect targets are word aligned; the low two address bits are dropped.
  assign jump_pc_d = jump_addr & 32'hFFFF_FFFC;

  // A redirect in the same cycle suppresses the hit so the decoder latches a NOP.
  assign hit_d     = rdy && !jump_en && (state_q == ST_IDLE) && lookup_hit_d;
  // A redirect during FILL abandons the line, so the cache write is suppressed too.
  assign fill_we_d = rdy && !jump_en && (state_q == ST_FILL);

  fetcher_icache #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (idx_d),
    .rd_tag_i  (tag_d),
    .hit_o     (lookup_hit_d),
    .data_o    (line_data_d),
    .we_i      (fill_we_d),
    .wr_idx_i  (idx_d),
    .wr_tag_i  (tag_d),
    .wr_data_i (fill_buf_q)
  );

  // Fetch sequencer: PC advance, miss detection, byte assembly and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= ZERO;
      byte_cnt_q <= 2'd0;
      fill_buf_q <= ZERO;
    end else if (rdy) begin
      if (jump_en) begin
        state_q    <= ST_IDLE;
        pc_q       <= jump_pc_d;
        mem_req_q  <= 1'b0;
        byte_cnt_q <= 2'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (lookup_hit_d) begin
              if (issue) begin
                pc_q <= pc_inc_d;
              end
            end else begin
              byte_cnt_q <= 2'd0;
              mem_addr_q <= pc_q;
              mem_req_q  <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (mem_valid) begin
              fill_buf_q[{byte_cnt_q, 3'b000} +: 8] <= mem_byte;
              if (byte_cnt_q != 2'd3) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                mem_addr_q <= mem_addr_q + 32'd1;
              end else begin
                mem_req_q <= 1'b0;
                state_q   <= ST_FILL;
              end
            end
          end
          ST_FILL: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pc_out   = pc_q;
  assign hit      = hit_d;
  assign inst_out = hit_d ? line_data_d : ZERO;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for the fetcher: cold start, warm loop, stall/freeze,
// redirect mid-fill, conflict eviction and reset mid-fill.
module tb_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        issue;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        mem_valid;
  logic [7:0]  mem_byte;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        hit;
  logic [31:0] pc_out;
  logic [31:0] inst_out;

  int checks;
  int errors;

  logic [7:0]  mem [0:1023];
  logic [31:0] exp_w [0:3];

  localparam logic [31:0] W10  = 32'h0042_0293;
  localparam logic [31:0] W40  = 32'h1357_9BDF;
  localparam logic [31:0] W80  = 32'hDEAD_BEEF;
  localparam logic [31:0] W100 = 32'hCAFE_F00D;

  fetcher #(
    .RESET_PC     (32'h0),
    .ICACHE_IDX_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .issue     (issue),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mem_valid (mem_valid),
    .mem_byte  (mem_byte),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .hit       (hit),
    .pc_out    (pc_out),
    .inst_out  (inst_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-cycle memory: answers any request in the cycle it is presented, never while rdy is low.
  assign mem_valid = mem_req && rdy;
  assign mem_byte  = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 8'h00;

  task automatic put_word(input int unsigned a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem[10'(a + b)] = w[8*b +: 8];
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; issue = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    step(); step();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", hit); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 00000000", inst_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", pc_out); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", mem_addr); end
  endtask

  task automatic test_cold_start();
    rst = 1'b0; issue = 1'b1;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_miss_hit got %0b want 0", hit); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(i)) begin errors++; $display("FAIL cold_addr%0d got req=%0b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, 32'(i)); end
    end
    step();
    checks++; if (hit !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL cold_fill got hit=%0b req=%0b want hit=0 req=0", hit, mem_req); end
    step();
    checks++; if (hit !== 1'b1 || inst_out !== 32'h0050_0093 || pc_out !== 32'h0) begin errors++; $display("FAIL cold_hit got hit=%0b inst=%h pc=%h want hit=1 inst=00500093 pc=00000000", hit, inst_out, pc_out); end
    step();
    checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL cold_advance got pc=%h want 00000004", pc_out); end
  endtask

  task automatic test_warm_loop();
    for (int k = 1; k < 4; k++) begin
      repeat (6) step();
      checks++; if (hit !== 1'b1 || pc_out !== 32'(4*k) || inst_out !== exp_w[k]) begin errors++; $display("FAIL fill%0d got hit=%0b pc=%h inst=%h want hit=1 pc=%h inst=%h", k, hit, pc_out, inst_out, 32'(4*k), exp_w[k]); end
      step();
    end
    jump_en = 1'b1; jump_addr = 32'h0000_0003;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL warm_jump_hit got %0b want 0", hit); end
    step();
    jump_en = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (hit !== 1'b1 || pc_out !== 32'(4*i) || inst_out !== exp_w[i] || mem_req !== 1'b0) begin errors++; $display("FAIL warm%0d got hit=%0b pc=%h inst=%h req=%0b want hit=1 pc=%h inst=%h req=0", i, hit, pc_out, inst_out, mem_req, 32'(4*i), exp_w[i]); end
      step();
    end
  endtask

  task automatic test_stall();
    issue = 1'b0; jump_en = 1'b1; jump_addr = 32'h8;
    step();
    jump_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (hit !== 1'b1 || pc_out !== 32'h8) begin errors++; $display("FAIL stall%0d got hit=%0b pc=%h want hit=1 pc=00000008", i, hit, pc_out); end
      step();
    end
    issue = 1'b1;
    step();
    checks++; if (hit !== 1'b1 || pc_out !== 32'hC || inst_out !== exp_w[3]) begin errors++; $display("FAIL stall_resume got hit=%0b pc=%h inst=%h want hit=1 pc=0000000c inst=%h", hit, pc_out, inst_out, exp_w[3]); end
    step();
    issue = 1'b0;
  endtask

  task automatic test_rdy_freeze();
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL frz_start got req=%0b addr=%h want req=1 addr=00000010", mem_req, mem_addr); end
    step();
    rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h11) begin errors++; $display("FAIL frz%0d got req=%0b addr=%h want req=1 addr=00000011", i, mem_req, mem_addr); end
    end
    rdy = 1'b1;
    step();
    checks++; if (mem_addr !== 32'h12) begin errors++; $display("FAIL frz_resume got addr=%h want 00000012", mem_addr); end
    repeat (3) step();
    checks++; if (hit !== 1'b1 || pc_out !== 32'h10 || inst_out !== W10) begin errors++; $display("FAIL frz_fill got hit=%0b pc=%h inst=%h want hit=1 pc=00000010 inst=%h", hit, pc_out, inst_out, W10); end
    rdy = 1'b0; issue = 1'b1;
    #1;
    checks++; if (hit !== 1'b0 || inst_out !== 32'h0) begin errors++; $display("FAIL rdy_low_hit got hit=%0b inst=%h want hit=0 inst=00000000", hit, inst_out); end
    step();
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL rdy_low_pc got pc=%h want 00000010", pc_out); end
    rdy = 1'b1; issue = 1'b0;
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rdy_back_hit got %0b want 1", hit); end
  endtask

  task automatic test_redirect_mid_fill();
    jump_en = 1'b1; jump_addr = 32'h40;
    step();
    jump_en = 1'b0;
    step(); step(); step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h42) begin errors++; $display("FAIL redir_pre got req=%0b addr=%h want req=1 addr=00000042", mem_req, mem_addr); end
    jump_en = 1'b1; jump_addr = 32'h100;
    step();
    jump_en = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc_out !== 32'h100 || hit !== 1'b0) begin errors++; $display("FAIL redir_drop got req=%0b pc=%h hit=%0b want req=0 pc=00000100 hit=0", mem_req, pc_out, hit); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL redir_next got req=%0b addr=%h want req=1 addr=00000100", mem_req, mem_addr); end
    repeat (5) step();
    checks++; if (hit !== 1'b1 || inst_out !== W100) begin errors++; $display("FAIL redir_fill got hit=%0b inst=%h want hit=1 inst=%h", hit, inst_out, W100); end
    jump_en = 1'b1; jump_addr = 32'h40;
    step();
    jump_en = 1'b0;
    #1;
    checks++; if (hit !== 1'b0 || pc_out !== 32'h40) begin errors++; $display("FAIL redir_old_line got hit=%0b pc=%h want hit=0 pc=00000040", hit, pc_out); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL redir_refetch got req=%0b addr=%h want req=1 addr=00000040", mem_req, mem_addr); end
    repeat (5) step();
    checks++; if (hit !== 1'b1 || inst_out !== W40) begin errors++; $display("FAIL redir_old_fill got hit=%0b inst=%h want hit=1 inst=%h", hit, inst_out, W40); end
  endtask

  task automatic test_conflict();
    jump_en = 1'b1; jump_addr = 32'h0;
    step();
    jump_en = 1'b0;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_evicted0 got hit=%0b want 0", hit); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL conf_fetch0 got req=%0b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
    repeat (5) step();
    checks++; if (hit !== 1'b1 || inst_out !== exp_w[0]) begin errors++; $display("FAIL conf_fill0 got hit=%0b inst=%h want hit=1 inst=%h", hit, inst_out, exp_w[0]); end
    jump_en = 1'b1; jump_addr = 32'h80;
    step();
    jump_en = 1'b0;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_miss80 got hit=%0b want 0", hit); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL conf_fetch80 got req=%0b addr=%h want req=1 addr=00000080", mem_req, mem_addr); end
    repeat (5) step();
    checks++; if (hit !== 1'b1 || inst_out !== W80) begin errors++; $display("FAIL conf_fill80 got hit=%0b inst=%h want hit=1 inst=%h", hit, inst_out, W80); end
    jump_en = 1'b1; jump_addr = 32'h0;
    step();
    jump_en = 1'b0;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_remiss0 got hit=%0b want 0", hit); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL conf_refetch0 got req=%0b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid_fill();
    jump_en = 1'b1; jump_addr = 32'h20;
    step();
    jump_en = 1'b0;
    step(); step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h21) begin errors++; $display("FAIL rstfill_pre got req=%0b addr=%h want req=1 addr=00000021", mem_req, mem_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || hit !== 1'b0 || pc_out !== 32'h0 || mem_addr !== 32'h0 || inst_out !== 32'h0) begin errors++; $display("FAIL rstfill_state got req=%0b hit=%0b pc=%h addr=%h inst=%h want 0 0 00000000 00000000 00000000", mem_req, hit, pc_out, mem_addr, inst_out); end
    jump_en = 1'b1; jump_addr = 32'h8;
    step();
    jump_en = 1'b0;
    #1;
    checks++; if (hit !== 1'b0 || pc_out !== 32'h8) begin errors++; $display("FAIL rstfill_inval got hit=%0b pc=%h want hit=0 pc=00000008", hit, pc_out); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL rstfill_refetch got req=%0b addr=%h want req=1 addr=00000008", mem_req, mem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    exp_w[0] = 32'h0050_0093;
    exp_w[1] = 32'h0010_8113;
    exp_w[2] = 32'h0021_0193;
    exp_w[3] = 32'h0031_8213;
    for (int i = 0; i < 4; i++) put_word(32'(4*i), exp_w[i]);
    put_word(32'h10, W10);
    put_word(32'h40, W40);
    put_word(32'h80, W80);
    put_word(32'h100, W100);

    test_reset();
    test_cold_start();
    test_warm_loop();
    test_stall();
    test_rdy_freeze();
    test_redirect_mid_fill();
    test_conflict();
    test_reset_mid_fill();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch front end feeding the dispatch decoder. Holds the architectural fetch PC and looks it up in a small direct-mapped instruction cache. On a miss, assembles the 32-bit little-endian instruction from four byte reads on the memory-controller port. Presents `pc_out`/`inst_out` with `hit`; the decoder latches them when dispatch asserts `issue`. Jump/branch redirects from execute retarget the PC and abort any fill in progress.

## Interface
- `RESET_PC`, 32'h0, PC loaded on reset
- `ICACHE_IDX_W`, 5, index width; cache holds 2^`ICACHE_IDX_W` one-word lines
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high reset
- `rdy` in 1: global enable; when low, all state frozen and `hit` forced 0
- `issue` in 1: dispatch consumes the presented instruction this cycle
- `jump_en` in 1: redirect request
- `jump_addr` in `addr_t`: redirect target (bits [1:0] ignored, treated as 0)
- `mem_valid` in 1: requested byte is on `mem_byte` this cycle
- `mem_byte` in 8: returned byte
- `mem_req` out 1: byte read request; held until `mem_valid`
- `mem_addr` out `addr_t`: byte address; stable while `mem_req` high
- `hit` out 1: `pc_out`/`inst_out` are a valid instruction
- `pc_out` out `addr_t`: current fetch PC
- `inst_out` out `inst_t`: cached instruction for `pc_out`; 0 when `hit`=0

## Operation
- Address split: offset pc[1:0] (always 0); index pc[ICACHE_IDX_W+1:2]; tag = remaining upper bits.
- `hit` (combinational) = `rdy` & !`jump_en` & state==IDLE & valid[idx] & tag match.
- States:
  - IDLE: on lookup miss (and no `jump_en`), set byte_cnt=0, `mem_addr`=pc, `mem_req`=1, go to FETCH.
  - FETCH: on each `mem_valid`, write `mem_byte` into buf[8*byte_cnt +: 8]. If byte_cnt<3, increment byte_cnt and `mem_addr`. If byte_cnt==3, drop `mem_req` and go to FILL.
  - FILL: write {valid=1, tag, buf} to line idx, go to IDLE.
- Advance: in IDLE with `hit` & `issue`, pc <= pc+4 (32-bit wrap, 32'hFFFFFFFC -> 0).
- Priority: `rst` > !`rdy` (freeze) > `jump_en` > advance/miss handling.
- `jump_en` in any state:
  - pc <= {jump_addr[31:2],2'b0}, `mem_req` <= 0, byte_cnt cleared, state <= IDLE.
  - Partial buf discarded; cache not written.
  - A `mem_valid` arriving in the same cycle is ignored.
- `jump_en` with `issue` and a would-be hit: `hit` is 0, so the decoder latches NOP; the redirect wins.
- Cache is never invalidated except by `rst` (no self-modifying code support).

## Timing
- Reset values:
  - pc=`RESET_PC`, state=IDLE, `mem_req`=0, `mem_addr`=0, byte_cnt=0, buf=0.
  - All valid bits cleared, so `hit`=0 and `inst_out`=0 after reset.
- Hit path: zero added latency. With `issue` held high, one instruction per cycle; `pc_out` advances the cycle after each consumed hit.
- Miss penalty:
  - Cycle after the miss is detected: `mem_req` high.
  - FILL occupies the cycle after the 4th `mem_valid`.
  - `hit` rises the next cycle.
  - With single-cycle memory response: 1 + 4 + 1 cycles miss-to-hit.
- Redirect: new PC looked up the cycle after `jump_en`. If that PC hits, `hit` is 1 in that cycle.
- `rdy` low mid-FETCH: `mem_req`/`mem_addr` hold their values; the memory model must not return data while `rdy` is low.

## Structure
- Shared defines: `addr_t`, `inst_t`, `word_t`, `ZERO`, plus `ICACHE_IDX_W` default and the fetcher state encodings (IDLE/FETCH/FILL).
- Sub-module `icache`:
  - Valid/tag/data arrays with combinational read (index, tag -> hit, data) and synchronous write port.
  - Valid bits cleared on `rst`.
- FSM, PC, and byte assembly stay in `fetcher`.

## Test plan
- Cold start: reset, memory word at 0 = 32'h00500093, 1-cycle memory latency, `issue`=1. Required: `mem_addr` 0,1,2,3 in sequence; `hit`=1 with `inst_out`=32'h00500093 and `pc_out`=0 six cycles after reset release; `pc_out`=4 next cycle.
- Warm loop: after 0x0–0xC are filled, `jump_en` to 0x0. Required: `hit`=1 on 0x0,4,8,C in four consecutive cycles with no `mem_req`.
- Redirect mid-fill: `jump_en`, `jump_addr`=0x100 after 2 of 4 bytes. Required: `mem_req` drops, line for the old PC stays invalid, next `mem_addr`=0x100.
- Conflict eviction (`ICACHE_IDX_W`=5): fill 0x000, then fetch 0x080 (same index). Required: refetch 0x080 from memory; returning to 0x000 misses again.
- Stall: `issue`=0 with hit at 0x8. Required: `pc_out` holds 0x8 and `hit` stays 1. `rdy`=0 for 3 cycles mid-FETCH: `mem_addr` unchanged, byte_cnt unchanged.
- Reset mid-fill: `rst` during FETCH. Required: next cycle `mem_req`=0, `hit`=0, `pc_out`=`RESET_PC`, all lines invalid.
